// File: rtl/minimax_uart_tx_if.sv
// Data-bus bundle between the minimax core and the UART transmitter.
// The core drives the request side; the UART returns registered read data.
interface minimax_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rreq;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output wmask, output rreq, input rdata);
    modport slave  (input addr, input wdata, input wmask, input rreq, output rdata);
endinterface

// File: rtl/minimax_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS word registers, byte FIFO,
// and a start/data/stop serialiser with back-to-back frames and no idle gap.
module minimax_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hffff_fff0,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    minimax_uart_tx_if.slave bus,
    output logic             tx
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
    localparam logic [AW:0] COUNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic [1:0]    r_state;
    logic [15:0]   r_div;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    logic          r_tx;
    logic [31:0]   r_rdata;

    logic          w_sel_tx;
    logic          w_sel_st;
    logic          w_wr;
    logic          w_full;
    logic          w_empty;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_div_zero;
    logic [7:0]    w_count8;
    logic [31:0]   w_status;
    logic          w_pop;
    logic [1:0]    w_state_next;
    logic [15:0]   w_div_next;
    logic [7:0]    w_shift_next;
    logic [2:0]    w_bit_next;
    logic          w_tx_next;

    assign w_sel_tx   = (bus.addr[31:2] == BASE_ADDR[31:2]);
    assign w_sel_st   = (bus.addr[31:2] == STATUS_ADDR[31:2]);
    assign w_wr       = (bus.wmask != 4'b0000);
    assign w_full     = (r_count == COUNT_FULL);
    assign w_empty    = (r_count == {(AW + 1){1'b0}});
    // Room is judged on the pre-edge count, so a same-cycle pop never admits a push into a full FIFO.
    assign w_push_req = w_wr & bus.wmask[0] & w_sel_tx;
    assign w_push     = w_push_req & ~w_full;
    assign w_ovf_set  = w_push_req & w_full;
    assign w_ovf_clr  = w_wr & bus.wmask[0] & w_sel_st & bus.wdata[3];
    assign w_div_zero = (r_div == 16'd0);
    assign w_count8   = {{(7 - AW){1'b0}}, r_count};
    assign w_status   = {16'h0000, w_count8, 4'h0, r_ovf, (r_state != ST_IDLE), w_empty, w_full};

    // Serialiser next-state: divider, shift register, bit index and FIFO pop.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                    w_div_next   = DIV_LAST;
                    w_shift_next = r_mem[r_rptr];
                    w_bit_next   = 3'd0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_div_zero) begin
                    w_state_next = ST_DATA;
                    w_div_next   = DIV_LAST;
                end else begin
                    w_div_next = r_div - 16'd1;
                end
            end
            ST_DATA: begin
                if (w_div_zero) begin
                    w_div_next = DIV_LAST;
                    if (r_bit == 3'd7) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_bit_next   = r_bit + 3'd1;
                    end
                end else begin
                    w_div_next = r_div - 16'd1;
                end
            end
            ST_STOP: begin
                if (w_div_zero) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                        w_div_next   = DIV_LAST;
                        w_shift_next = r_mem[r_rptr];
                        w_bit_next   = 3'd0;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_div_next = r_div - 16'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so tx is registered without a cycle of lag.
    always_comb begin
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wptr] <= bus.wdata[7:0];
        end else begin
            r_mem[r_wptr] <= r_mem[r_wptr];
        end
    end

    // Control state, FIFO bookkeeping, sticky overflow and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW + 1){1'b0}};
            r_ovf   <= 1'b0;
            r_state <= ST_IDLE;
            r_div   <= 16'd0;
            r_shift <= 8'd0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
            r_rdata <= 32'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            r_rdata <= (bus.rreq && w_sel_st) ? w_status : 32'd0;
        end
    end

    assign tx        = r_tx;
    assign bus.rdata = r_rdata;
endmodule

// File: doc/minimax_uart_tx.md
# minimax_uart_tx

Memory-mapped UART transmitter on the minimax data bus, sitting directly downstream of the core's `addr`/`wdata`/`wmask`/`rreq` port alongside the shared RAM. It decodes two word registers near the top of the address map, queues written bytes in a small FIFO and serialises them as 8N1 frames on `tx`. It returns status through a registered `rdata` that is zero when not selected, so the bench or SoC can OR it with the RAM read data.

## Interface
- `BASE_ADDR`, default 32'hffff_fff0: word-aligned base address; TXDATA at BASE+0, STATUS at BASE+4.
- `CLK_DIV`, default 16: clocks per UART bit. Legal range 2..65535.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of two, 2..64.

- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `addr` input 32: data-bus byte address from the core.
- `wdata` input 32: write data.
- `wmask` input 4: byte write enables; a write occurs in any cycle where the mask is nonzero.
- `rreq` input 1: read request.
- `rdata` output 32: registered read data; 0 when not selected.
- `tx` output 1: serial line, idle high.

## Operation
- Register selection is a match on `addr[31:2]` against `BASE_ADDR[31:2]` and against `(BASE_ADDR+4)[31:2]`. `addr[1:0]` is ignored.
- TXDATA write (`wmask[0]`=1):
  - If FIFO count < FIFO_DEPTH at the start of the cycle, push `wdata[7:0]`.
  - Otherwise drop the byte and set sticky OVF.
  - A pop in the same cycle does not make room for the push.
- STATUS write (`wmask[0]`=1) with `wdata[3]`=1 clears OVF. All other STATUS bits are read-only.
- STATUS read value:
  - bit0 FULL (count==DEPTH)
  - bit1 EMPTY (count==0)
  - bit2 BUSY (FSM not IDLE)
  - bit3 OVF
  - bits[15:8] count
  - all other bits 0
- Reads of TXDATA return 0.
- FIFO: circular buffer with log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head into the shift register, load the bit counter to 0 and the divider to CLK_DIV-1, then go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: `tx`=shift[0], LSB first. After each CLK_DIV cycles, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Divider: counts down from CLK_DIV-1 to 0; the bit boundary is at 0. Divider width is 16 bits.
- `tx` is a registered output.

## Timing
- Reset values:
  - `tx`=1
  - `rdata`=0
  - FSM=IDLE
  - pointers=0, count=0
  - OVF=0
  - divider and shift register=0
- `reset` asserted mid-frame aborts the frame: `tx`=1 on the next edge and FIFO contents are discarded.
- Write-to-line latency, FIFO previously empty and FSM in IDLE:
  - Push at edge E0.
  - Pop and `tx` falls at edge E1.
  - The start bit spans E1..E1+CLK_DIV-1.
- A frame is exactly 10*CLK_DIV cycles. Back-to-back frames have no gap.
- Read latency is one cycle. `rdata` is updated on every edge:
  - If `rreq` && STATUS selected, load the STATUS value sampled at that edge. This is pre-edge state, so it excludes a push in the same cycle.
  - Otherwise load 0.
- `rreq` and a write in the same cycle to STATUS: the read returns pre-clear OVF, and the clear takes effect at that edge.
- A pop and a push in the same cycle with count<DEPTH leaves count unchanged.

## Test plan
- Reset with CLK_DIV=4, then hold for 5 cycles -> `tx`=1, `rdata`=0. A STATUS read returns 32'h0000_0002.
- Write 8'hA5 to TXDATA at edge E0 -> `tx` is 0 for E1..E4, then the data bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. BUSY=1 throughout and EMPTY=1 after E1.
- Write 3 bytes 8'h01, 8'h02, 8'h03 on consecutive cycles -> three frames, 120 cycles contiguous with no idle cycle between them. Count reads 2, 1, 0 at the respective pops.
- With DEPTH=8 and the FSM busy, write 10 bytes while the first frame is mid-transmission -> bytes 1..9 are queued (first popped, 8 in FIFO), byte 10 is dropped, OVF=1 and FULL=1. Writing STATUS with 32'h8 clears OVF, and the FIFO still drains 9 frames.
- Assert `reset` during the DATA state of a frame with 3 bytes queued -> `tx`=1 at the next edge, STATUS reads 32'h0000_0002, and no further frames are sent.
- Read TXDATA, and read any address outside BASE..BASE+7 -> `rdata`=0 one cycle later, and a write to a non-matching address does not change count.
